// File: rtl/qsys_multi_timer_if.sv
// Avalon-MM slave bundle for the multi-channel interval timer.
// Address is {channel, offset[2:0]}; irq lines travel with the bus.
interface qsys_multi_timer_if #(
    parameter int NUM_CH = 2
);
    localparam int CH_AW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_W = CH_AW + 3;

    logic              chipselect;
    logic [ADDR_W-1:0] address;
    logic              write_n;
    logic [15:0]       writedata;
    logic [15:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;

    modport master (
        output chipselect, address, write_n, writedata,
        input  readdata, irq, irq_vec
    );

    modport slave (
        input  chipselect, address, write_n, writedata,
        output readdata, irq, irq_vec
    );
endinterface

// File: rtl/qsys_multi_timer.sv
// N-channel Avalon-MM interval timer: per-channel down-counter,
// period, snapshot, prescaler, one-shot/continuous mode and irq.
module qsys_multi_timer #(
    parameter int          NUM_CH     = 2,
    parameter int          COUNT_W    = 32,
    parameter int          PRESC_W    = 8,
    parameter logic [31:0] RST_PERIOD = 32'h002F_AF07
) (
    input logic               clk,
    input logic               reset_n,
    qsys_multi_timer_if.slave bus
);
    localparam int CH_AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [COUNT_W-1:0] RST_CNT = RST_PERIOD[COUNT_W-1:0];

    logic [CH_AW-1:0]   ch;
    logic [2:0]         off;
    logic               ch_ok;
    logic               wr;

    logic [COUNT_W-1:0] cnt   [NUM_CH];
    logic [COUNT_W-1:0] per   [NUM_CH];
    logic [COUNT_W-1:0] snap  [NUM_CH];
    logic [PRESC_W-1:0] presc [NUM_CH];
    logic [PRESC_W-1:0] psc   [NUM_CH];
    logic [3:0]         ctrl  [NUM_CH];
    logic [NUM_CH-1:0]  run;
    logic [NUM_CH-1:0]  to;
    logic [NUM_CH-1:0]  zq;
    logic [NUM_CH-1:0]  pend;

    logic [31:0]        per32  [NUM_CH];
    logic [31:0]        snap32 [NUM_CH];
    logic [NUM_CH-1:0]  sel;
    logic [NUM_CH-1:0]  w_stat;
    logic [NUM_CH-1:0]  w_ctrl;
    logic [NUM_CH-1:0]  w_perl;
    logic [NUM_CH-1:0]  w_perh;
    logic [NUM_CH-1:0]  w_snap;
    logic [NUM_CH-1:0]  w_presc;
    logic [NUM_CH-1:0]  start;
    logic [NUM_CH-1:0]  stop;
    logic [NUM_CH-1:0]  tick;
    logic [NUM_CH-1:0]  zero;
    logic [NUM_CH-1:0]  ito;
    logic [15:0]        rd_next;

    assign ch    = bus.address[CH_AW+2:3];
    assign off   = bus.address[2:0];
    assign ch_ok = 32'(ch) < NUM_CH;
    assign wr    = bus.chipselect & ~bus.write_n;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i]     = wr & ch_ok & (ch == CH_AW'(i));
            w_stat[i]  = sel[i] & (off == 3'd0);
            w_ctrl[i]  = sel[i] & (off == 3'd1);
            w_perl[i]  = sel[i] & (off == 3'd2);
            w_perh[i]  = sel[i] & (off == 3'd3);
            w_snap[i]  = sel[i] & ((off == 3'd4) | (off == 3'd5));
            w_presc[i] = sel[i] & (off == 3'd6);
            start[i]   = w_ctrl[i] & bus.writedata[2];
            stop[i]    = w_ctrl[i] & bus.writedata[3];
            per32[i]   = 32'(per[i]);
            snap32[i]  = 32'(snap[i]);
            zero[i]    = (cnt[i] == '0);
            ito[i]     = ctrl[i][0];
            // START restarts only the prescaler, so it also masks this tick
            tick[i]    = run[i] & (psc[i] == presc[i]) & ~start[i]
                       & ~w_perl[i] & ~w_perh[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]   <= RST_CNT;
                per[i]   <= RST_CNT;
                snap[i]  <= '0;
                presc[i] <= '0;
                psc[i]   <= '0;
                ctrl[i]  <= '0;
            end
            run  <= '0;
            to   <= '0;
            zq   <= {NUM_CH{RST_CNT == '0}};
            pend <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                zq[i]   <= zero[i];
                to[i]   <= (zero[i] & ~zq[i]) | (to[i] & ~w_stat[i]);
                pend[i] <= w_perl[i] | w_perh[i];

                if (w_ctrl[i])
                    ctrl[i] <= bus.writedata[3:0];
                if (w_presc[i])
                    presc[i] <= PRESC_W'(bus.writedata);
                if (w_perl[i])
                    per[i] <= COUNT_W'({per32[i][31:16], bus.writedata});
                else if (w_perh[i])
                    per[i] <= COUNT_W'({bus.writedata, per32[i][15:0]});
                if (w_snap[i])
                    snap[i] <= cnt[i];

                if (start[i] | w_perl[i] | w_perh[i])
                    psc[i] <= '0;
                else if (run[i])
                    psc[i] <= (psc[i] == presc[i]) ? '0 : psc[i] + 1'b1;

                if (start[i])
                    run[i] <= 1'b1;
                else if (stop[i] | w_perl[i] | w_perh[i]
                         | (tick[i] & zero[i] & ~ctrl[i][1]))
                    run[i] <= 1'b0;

                // one-shot parks at zero; continuous reloads
                if (pend[i])
                    cnt[i] <= per[i];
                else if (tick[i]) begin
                    if (!zero[i])
                        cnt[i] <= cnt[i] - 1'b1;
                    else if (ctrl[i][1])
                        cnt[i] <= per[i];
                end
            end
        end
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_ok && (ch == CH_AW'(i))) begin
                case (off)
                    3'd0:    rd_next = {14'd0, run[i], to[i]};
                    3'd1:    rd_next = {12'd0, ctrl[i]};
                    3'd2:    rd_next = per32[i][15:0];
                    3'd3:    rd_next = per32[i][31:16];
                    3'd4:    rd_next = snap32[i][15:0];
                    3'd5:    rd_next = snap32[i][31:16];
                    3'd6:    rd_next = 16'(presc[i]);
                    default: rd_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.readdata <= '0;
        else
            bus.readdata <= rd_next;
    end

    assign bus.irq_vec = to & ito;
    assign bus.irq     = |(to & ito);

endmodule
